fpu_i2f_writeback: RTL and testbench
====================================

# fpu_i2f_writeback

Registered result stage directly downstream of the integer-to-float converter. It captures each converted float, the destination register tag and the invalid/inexact flags into a 2-entry buffer, and presents them to the FP register-file write port with a valid/ready handshake. It also keeps the architectural accrued exception-flags register (RISC-V `fflags`) up to date as results retire, and supports a pipeline flush.

## Interface
Parameters:
- `std`, 31 — MSB index of the float result (31 = IEEE32, 15 = IEEE16/bfloat16).
- `tag_w`, 5 — width of the destination-register tag.

Ports:
- `clk` in 1 — single clock; every register updates on its rising edge.
- `rst` in 1 — reset is synchronous and active-high.
- `flush` in 1 — drops all buffered entries and any push in the same cycle.
- `in_valid` in 1 — a converter result is present.
- `in_ready` out 1 — the buffer can accept a result this cycle.
- `in_float` in std+1 — converter float output.
- `in_invalid` in 1 — converter invalid flag.
- `in_inexact` in 1 — converter inexact flag.
- `in_rd` in tag_w — destination FP register.
- `wb_valid` out 1 — head entry is valid.
- `wb_ready` in 1 — the register-file port accepts the head entry.
- `wb_data` out std+1 — head float.
- `wb_rd` out tag_w — head destination register.
- `wb_flags` out 5 — head flags, ordered {NV,DZ,OF,UF,NX}.
- `fflags_we` in 1 — CSR write strobe.
- `fflags_wdata` in 5 — CSR write data.
- `fflags` out 5 — accrued flags.

## Operation
- Entry flags are {in_invalid,0,0,0,in_inexact}. DZ, OF and UF are always 0 for this stage.
- 2-entry circular FIFO with head pointer `hd` (1 bit), tail pointer `tl` (1 bit) and `count` (0..2).
- `in_ready` = (count != 2). It is a function of registered state only and never depends on `in_valid`.
- Push = in_valid & in_ready & ~flush. Pop = wb_valid & wb_ready & ~flush.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Pointers wrap from 1 to 0.
- Full (count = 2): `in_ready` = 0; the upstream holds `in_float` stable.
- Empty (count = 0): `wb_valid` = 0. `wb_data`, `wb_rd` and `wb_flags` then show the stale head entry and are don't-care.
- `wb_*` come directly from the head entry register, with no combinational path from the `in_*` inputs.
- `flush`: next cycle count = 0 and hd = tl = 0. A push or pop in the flush cycle is discarded. `fflags` is not updated by discarded entries.
- fflags update priority per cycle:
  - If fflags_we: fflags <= fflags_wdata | (pop ? head_flags : 0).
  - Else if pop: fflags <= fflags | head_flags.
  - Otherwise it holds.
- Retiring flags are never lost on a simultaneous CSR write.

## Timing
- Latency: a result pushed in cycle N is visible on `wb_*` in cycle N+1 if the buffer was empty or popping.
- Throughput: 1 result per cycle with `wb_ready` held high.
- `fflags` reflects a popped entry in the cycle after the pop.
- Reset values: count = 0, hd = tl = 0, `wb_valid` = 0, `in_ready` = 1 from the first cycle after reset, `fflags` = 5'b0, `wb_data`/`wb_rd`/`wb_flags` = 0.
- Reset mid-operation discards all entries and does not update `fflags`. Reset dominates `flush` and `fflags_we`.
- Handshake rule: once `wb_valid` is asserted, `wb_valid`, `wb_data`, `wb_rd` and `wb_flags` stay stable until a pop, a flush or a reset.

## Configuration
- `FPU_WB_FLAG_ACC_EN` defined: the `fflags` register and its CSR write path are built as described above.
- `FPU_WB_FLAG_ACC_EN` not defined:
  - `fflags` is tied to 5'b0.
  - `fflags_we` and `fflags_wdata` are ignored.
  - Per-entry `wb_flags` is still produced, so accrual happens in the CSR unit instead.

## Structure
- The shared FPU package holds:
  - Flag bit-index constants NV = 4, DZ = 3, OF = 2, UF = 1, NX = 0.
  - The 5-bit flags typedef.
  - The `fpu_wb_entry` struct {float, rd, flags}.
- One sub-module, `fpu_wb_fifo2`: the generic 2-entry valid/ready buffer, parameterised by payload width.
- The top level packs and unpacks entries and holds the fflags logic.

## Test plan
- Single push of float 32'h3F800000, rd = 3, flags 0, with `wb_ready` = 1: `wb_valid` = 1 in the next cycle with the same data; `fflags` stays 0.
- Hold `wb_ready` = 0 and push 3 times: `in_ready` drops after the 2nd push. Then release `wb_ready`: entries pop in order (data A, then B), and `in_ready` returns 1 the cycle after the first pop.
- Pop an entry with inexact = 1 (16777217 converted to 32'h4B800000): `wb_flags` = 5'b00001, and `fflags` = 5'b00001 the next cycle.
- In the same cycle, pop an entry with flags 5'b00001 and apply `fflags_we` with wdata 5'b10000: `fflags` = 5'b10001.
- Fill 2 entries, then assert `flush` together with `in_valid`: the next cycle `wb_valid` = 0, count = 0, `fflags` is unchanged, and `in_ready` = 1.
- Assert `rst` with 2 entries buffered and `fflags` = 5'b00001: the next cycle all outputs are at their reset values and `fflags` = 0. Rebuild without `FPU_WB_FLAG_ACC_EN`: `fflags` stays 0 after an inexact pop.

Source files
------------

// File: rtl/fpu_i2f_writeback_pkg.sv
// fpu_i2f_writeback_pkg: shared FPU flag indices, flag type and writeback entry layout
package fpu_i2f_writeback_pkg;

    localparam int NV = 4;
    localparam int DZ = 3;
    localparam int OF = 2;
    localparam int UF = 1;
    localparam int NX = 0;

    typedef logic [4:0] fflags_t;

    // Default-width (IEEE32, 5-bit tag) view of one buffered writeback entry
    typedef struct packed {
        logic [31:0] fp;
        logic [4:0]  rd;
        fflags_t     flags;
    } fpu_wb_entry;

endpackage

// File: rtl/fpu_i2f_writeback_fifo2.sv
// fpu_wb_fifo2: generic 2-entry valid/ready circular buffer with synchronous flush
module fpu_wb_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         pop
);

    logic [W-1:0] mem_q [2];
    logic         hd_q, hd_d, tl_q, tl_d, push;
    logic [1:0]   cnt_q, cnt_d;

    assign in_ready  = cnt_q != 2'd2;
    assign out_valid = cnt_q != 2'd0;
    assign out_data  = mem_q[hd_q];
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    // Pointer/count next state; flush returns the buffer to its empty home position
    always_comb begin
        hd_d  = flush ? 1'b0 : hd_q ^ pop;
        tl_d  = flush ? 1'b0 : tl_q ^ push;
        cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
    end

    // State and storage registers; payload is only written on an accepted push
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            hd_q     <= 1'b0;
            tl_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
            if (push) mem_q[tl_q] <= in_data;
        end
    end

endmodule

// File: rtl/fpu_i2f_writeback.sv
// fpu_i2f_writeback: int-to-float result buffer and fflags accrual; FPU_WB_FLAG_ACC_EN builds the fflags register
module fpu_i2f_writeback
    import fpu_i2f_writeback_pkg::*;
#(
    parameter int std   = 31,
    parameter int tag_w = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [std:0]     in_float,
    input  logic             in_invalid,
    input  logic             in_inexact,
    input  logic [tag_w-1:0] in_rd,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [std:0]     wb_data,
    output logic [tag_w-1:0] wb_rd,
    output logic [4:0]       wb_flags,
    input  logic             fflags_we,
    input  logic [4:0]       fflags_wdata,
    output logic [4:0]       fflags
);

    // Same layout as fpu_wb_entry, sized by this instance's parameters
    typedef struct packed {
        logic [std:0]     fp;
        logic [tag_w-1:0] rd;
        fflags_t          flags;
    } entry_t;

    entry_t  in_e, wb_e;
    fflags_t in_flags;
    logic    pop;

    // Converter only raises invalid and inexact
    always_comb begin
        in_flags     = '0;
        in_flags[NV] = in_invalid;
        in_flags[NX] = in_inexact;
    end

    assign in_e     = '{fp: in_float, rd: in_rd, flags: in_flags};
    assign wb_data  = wb_e.fp;
    assign wb_rd    = wb_e.rd;
    assign wb_flags = wb_e.flags;

    fpu_wb_fifo2 #(.W($bits(entry_t))) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_e),
        .out_valid (wb_valid),
        .out_ready (wb_ready),
        .out_data  (wb_e),
        .pop       (pop)
    );

`ifdef FPU_WB_FLAG_ACC_EN
    fflags_t fflags_q, fflags_d, ret_flags;

    // Retiring flags are merged into a CSR write so they are never lost
    always_comb begin
        ret_flags = pop ? wb_e.flags : '0;
        fflags_d  = fflags_we ? (fflags_wdata | ret_flags) : (fflags_q | ret_flags);
    end

    // Accrued exception flags register
    always_ff @(posedge clk) begin
        if (rst) fflags_q <= '0;
        else     fflags_q <= fflags_d;
    end

    assign fflags = fflags_q;
`else
    logic unused_csr;
    assign unused_csr = ^{fflags_we, fflags_wdata};
    assign fflags     = '0;
`endif

endmodule

// File: tb/tb_fpu_i2f_writeback.sv
// tb_fpu_i2f_writeback: directed plus randomized checks against a queue-based reference model
module tb_fpu_i2f_writeback;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, in_invalid = 0, in_inexact = 0;
    logic        wb_ready = 0, fflags_we = 0;
    logic [31:0] in_float = 0;
    logic [4:0]  in_rd = 0, fflags_wdata = 0;
    logic        in_ready, wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd, wb_flags, fflags;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  rd;
        logic [4:0]  f;
    } ent_t;

    ent_t        q[$];
    logic [4:0]  ff = 0;
    int          vec = 0, errs = 0;

    fpu_i2f_writeback dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_float(in_float), .in_invalid(in_invalid), .in_inexact(in_inexact), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_flags(wb_flags), .fflags_we(fflags_we), .fflags_wdata(fflags_wdata), .fflags(fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
        chk("wb_valid", {31'b0, wb_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
            chk("wb_data", wb_data, q[0].d);
            chk("wb_rd", {27'b0, wb_rd}, {27'b0, q[0].rd});
            chk("wb_flags", {27'b0, wb_flags}, {27'b0, q[0].f});
        end
        chk("fflags", {27'b0, fflags}, {27'b0, ff});
    endtask

    // One clock: predict from pre-edge inputs, advance the model, compare after the edge
    task automatic step();
        ent_t       e;
        bit         push, pop;
        logic [4:0] hf;
        e    = '{d: in_float, rd: in_rd, f: {in_invalid, 3'b000, in_inexact}};
        push = in_valid && q.size() < 2 && !flush;
        pop  = wb_ready && q.size() > 0 && !flush;
        hf   = pop ? q[0].f : 5'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            ff = 0;
        end else begin
`ifdef FPU_WB_FLAG_ACC_EN
            ff = fflags_we ? (fflags_wdata | hf) : (ff | hf);
`endif
            if (flush) q.delete();
            else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e);
            end
        end
        check_outputs();
    endtask

    task automatic check_reset_vals();
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_fflags", {27'b0, fflags}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'b0, wb_rd}, 32'd0);
        chk("rst_wb_flags", {27'b0, wb_flags}, 32'd0);
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd, input logic nv, input logic nx);
        in_valid = v; in_float = d; in_rd = rd; in_invalid = nv; in_inexact = nx;
    endtask

    initial begin
        step();
        step();
        check_reset_vals();
        rst = 0;
        step();
        // single push, next-cycle visibility
        wb_ready = 1;
        drive(1, 32'h3F80_0000, 5'd3, 0, 0);
        step();
        chk("single_valid", {31'b0, wb_valid}, 32'd1);
        chk("single_data", wb_data, 32'h3F80_0000);
        drive(0, 0, 0, 0, 0);
        step();
        // backpressure: three pushes with wb_ready low
        wb_ready = 0;
        drive(1, 32'hAAAA_0001, 5'd1, 0, 0); step();
        drive(1, 32'hBBBB_0002, 5'd2, 1, 0); step();
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        drive(1, 32'hCCCC_0003, 5'd4, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        wb_ready = 1;
        step();
        chk("order_b", wb_data, 32'hBBBB_0002);
        chk("ready_after_pop", {31'b0, in_ready}, 32'd1);
        step();
        step();
        // inexact entry accrues NX
        drive(1, 32'h4B80_0000, 5'd7, 0, 1); step();
        drive(0, 0, 0, 0, 0);
        chk("nx_flags", {27'b0, wb_flags}, 32'd1);
        step();
        step();
`ifdef FPU_WB_FLAG_ACC_EN
        chk("nx_fflags", {27'b0, fflags}, 32'd1);
`else
        chk("nx_fflags_off", {27'b0, fflags}, 32'd0);
`endif
        // pop coinciding with CSR write
        fflags_we = 1; fflags_wdata = 5'b0; step(); fflags_we = 0;
        wb_ready = 0;
        drive(1, 32'h4B80_0000, 5'd9, 0, 1); step();
        drive(0, 0, 0, 0, 0);
        wb_ready = 1; fflags_we = 1; fflags_wdata = 5'b10000;
        step();
        fflags_we = 0;
`ifdef FPU_WB_FLAG_ACC_EN
        chk("csr_merge", {27'b0, fflags}, 32'b10001);
`else
        chk("csr_merge_off", {27'b0, fflags}, 32'd0);
`endif
        // flush with a simultaneous push
        wb_ready = 0;
        drive(1, 32'h1111_1111, 5'd10, 1, 1); step();
        drive(1, 32'h2222_2222, 5'd11, 0, 1); step();
        flush = 1; drive(1, 32'h3333_3333, 5'd12, 0, 0); step();
        flush = 0; drive(0, 0, 0, 0, 0);
        chk("flush_valid", {31'b0, wb_valid}, 32'd0);
        chk("flush_ready", {31'b0, in_ready}, 32'd1);
        // reset mid-operation with fflags set
        fflags_we = 1; fflags_wdata = 5'b00001; step(); fflags_we = 0;
        drive(1, 32'h5555_5555, 5'd13, 0, 1); step();
        drive(1, 32'h6666_6666, 5'd14, 1, 0); step();
        drive(0, 0, 0, 0, 0);
        rst = 1; wb_ready = 1; step(); rst = 0;
        check_reset_vals();
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom), 1'($urandom), 1'($urandom));
            wb_ready     = $urandom_range(0, 2) != 0;
            flush        = $urandom_range(0, 30) == 0;
            fflags_we    = $urandom_range(0, 15) == 0;
            fflags_wdata = 5'($urandom);
            rst          = $urandom_range(0, 100) == 0;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
